lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store unit that drives the core's data-memory port as its initiator. Accepts one load or store request from the execute stage over a valid/ready handshake and issues word-wide reads and writes on the memory interface. Sub-word stores use read-modify-write because the memory accepts only full-word writes. Returns sign- or zero-extended load data, or an error flag, over a valid/ready response handshake to writeback.

## Interface
- Parameters: none. The datapath is fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; used bits [7:0] / [15:0] / [31:0]
- resp_valid  out  1  response present
- resp_ready  in  1  writeback accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or illegal funct3
- m_addr  out  32  word index, {2'b00, addr[31:2]}
- m_wr_dat  out  32  write data
- m_rd_en  out  1  read strobe
- m_wr_en  out  1  write strobe
- m_rd_dat  in  32  read data, registered by memory, valid the cycle after the m_rd_en edge

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch we, funct3, addr, wdata.
  - Error cases go to RESP with err=1 and no memory access:
    - illegal funct3: 011, 110, 111; or a store with funct3[2]=1
    - misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0
  - SW → WRITE. Loads, SB and SH → READ.
- **READ**: m_rd_en=1, m_addr=word index → WAIT.
- **WAIT**: sample m_rd_dat.
  - Load: extract lane, extend, store in the response register → RESP.
  - SB/SH: merge store bytes into the sampled word → WRITE.
- **WRITE**: m_wr_en=1, m_addr=word index, m_wr_dat=merged word (or wdata for SW) → RESP.
- **RESP**: resp_valid=1 and payload held stable until resp_ready=1 → IDLE. No new request is accepted in the same cycle.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], k=addr[1:0]. Halfword lane = addr[1].
- Extension:
  - B/H: sign-extend from bit 7 or 15.
  - BU/HU: zero-extend.
- m_rd_en and m_wr_en are never high together. Both are 0 outside READ and WRITE respectively. m_addr and m_wr_dat are 0 when their strobe is low.
- Reset:
  - Next state is IDLE. The response register and latched request are cleared.
  - m_rd_en and m_wr_en are gated by !reset, so no strobe is asserted in any cycle where reset=1. This holds even mid-RMW; the partial transaction is dropped.
- Reset values: req_ready=0 during reset (1 the cycle after); resp_valid=0, resp_rdata=0, resp_err=0, m_rd_en=0, m_wr_en=0, m_addr=0, m_wr_dat=0.

## Timing
Request accepted at edge N:
- Error: resp_valid from cycle N+1.
- SW: WRITE in N+1, resp_valid from N+2.
- Load: READ in N+1, WAIT in N+2, resp_valid from N+3.
- SB/SH: READ N+1, WAIT N+2, WRITE N+3, resp_valid from N+4.
- Throughput: at most one request in flight. The earliest next accept is the cycle after the resp handshake.
- A resp_ready stall holds RESP indefinitely with no memory activity.

## Structure
- Package lsu_pkg:
  - state enum lsu_state_t
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - lane-select helper functions
- Sub-module lsu_align, purely combinational:
  - load extract/extend: word, addr[1:0], funct3 → rdata
  - store merge: old word, wdata, addr[1:0], funct3 → new word
- The FSM and registers live in lsu_mem_master. The bench pairs it with a behavioural word memory that has registered one-cycle read latency.

## Test plan
- Load paths, with mem[0x40]=0x8899AABB:
  - LW addr 0x100 → one m_rd_en with m_addr=0x40; resp_rdata=0x8899AABB, err=0, at N+3.
  - LB addr 0x103 → 0xFFFFFF88.
  - LBU addr 0x103 → 0x00000088.
  - LH addr 0x102 → 0xFFFF8899.
  - LHU addr 0x100 → 0x0000AABB.
- SB addr 0x101, wdata 0x123456CC, mem[0x40]=0x8899AABB → read at N+1, write 0x8899CCBB at N+3, response at N+4 with rdata=0.
- SW addr 0x104, wdata 0xDEADBEEF → single m_wr_en at N+1 with m_addr=0x41, no read; response at N+2.
- Error cases, each with no strobe and err=1 at N+1:
  - LW addr 0x102
  - SH addr 0x101
  - load funct3=011
- Response backpressure: resp_ready held 0 for 5 cycles → resp_valid and payload stable, req_ready=0, no strobes. Release → IDLE next cycle.
- Reset asserted in the WAIT cycle of an SH → no m_wr_en ever; all outputs at reset values; next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [15:0] lane_half(input logic [31:0] word, input logic hsel);
    return hsel ? word[31:16] : word[15:0];
  endfunction

  // Unsigned sizes only exist for loads; H/W need natural alignment.
  function automatic logic req_error(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_BU:   e = we;
      F3_H:    e = off[0];
      F3_HU:   e = we | off[0];
      F3_W:    e = (off != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_mem_master_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load path: select the addressed lane and extend it.
  always_comb begin
    w_byte = lane_byte(i_word, i_off);
    w_half = lane_half(i_word, i_off[1]);
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h000000, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0000, w_half};
      F3_W:    o_rdata = i_word;
      default: o_rdata = 32'h00000000;
    endcase
  end

  // Store path: overlay the store lane onto the word read back from memory.
  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B:    o_merged[{i_off, 3'b000} +: 8]     = i_wdata[7:0];
      F3_H:    o_merged[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit FSM driving a word-wide memory; sub-word stores use read-modify-write.
module lsu_mem_master
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wr_dat,
  output logic        m_rd_en,
  output logic        m_wr_en,
  input  logic [31:0] m_rd_dat
);

  lsu_state_t  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] w_ext;
  logic [31:0] w_merged;
  logic        w_rd_strobe;
  logic        w_wr_strobe;

  lsu_align u_align (
    .i_word   (m_rd_dat),
    .i_wdata  (r_wdata),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_rdata  (w_ext),
    .o_merged (w_merged)
  );

  // Request FSM; r_wdata is overwritten with the merged word during an RMW.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h00000000;
      r_wdata  <= 32'h00000000;
      r_rdata  <= 32'h00000000;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_rdata  <= 32'h00000000;
            if (req_error(req_we, req_funct3, req_addr[1:0])) begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_err   <= 1'b0;
              r_state <= (req_we && (req_funct3 == F3_W)) ? S_WRITE : S_READ;
            end
          end
        end
        S_READ:  r_state <= S_WAIT;
        S_WAIT: begin
          if (r_we) begin
            r_wdata <= w_merged;
            r_state <= S_WRITE;
          end else begin
            r_rdata <= w_ext;
            r_state <= S_RESP;
          end
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from state and suppressed in any cycle with reset high.
  assign w_rd_strobe = (r_state == S_READ)  && !reset;
  assign w_wr_strobe = (r_state == S_WRITE) && !reset;

  assign m_rd_en    = w_rd_strobe;
  assign m_wr_en    = w_wr_strobe;
  assign m_addr     = (w_rd_strobe || w_wr_strobe) ? {2'b00, r_addr[31:2]} : 32'h00000000;
  assign m_wr_dat   = w_wr_strobe ? r_wdata : 32'h00000000;
  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign resp_valid = (r_state == S_RESP) && !reset;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a registered one-cycle-latency word memory.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] m_addr;
  logic [31:0] m_wr_dat;
  logic        m_rd_en;
  logic        m_wr_en;
  logic [31:0] m_rd_dat;

  logic [31:0] mem [0:255];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_waddr = 8'h0;
  logic [31:0] tb_wdata = 32'h0;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; int at; } op_t;
  typedef struct { logic [31:0] rdata; bit err; int at; } rsp_t;
  op_t  op_q[$];
  rsp_t rsp_q[$];

  lsu_mem_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_addr(m_addr), .m_wr_dat(m_wr_dat), .m_rd_en(m_rd_en), .m_wr_en(m_wr_en),
    .m_rd_dat(m_rd_dat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (m_rd_en) m_rd_dat <= mem[m_addr[7:0]];
    if (m_wr_en) mem[m_addr[7:0]] <= m_wr_dat;
    if (tb_we)   mem[tb_waddr] <= tb_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: rd=%b wr=%b resp_valid=%b (cycle %0d)", name, m_rd_en, m_wr_en, resp_valid, cyc);
  endtask

  // Monitor: pops expected memory ops and responses whenever the DUT presents them.
  task automatic monitor();
    bit   prev_v = 1'b0;
    op_t  o;
    rsp_t r;
    forever begin
      @(negedge clk);
      chk("strobe_exclusive", {31'd0, m_rd_en & m_wr_en}, 32'd0);
      if (m_rd_en || m_wr_en) begin
        if (op_q.size() == 0) begin
          flag("unexpected_strobe");
        end else begin
          o = op_q.pop_front();
          chk("op_kind", {31'd0, m_wr_en}, {31'd0, o.wr});
          chk("op_addr", m_addr, o.addr);
          if (o.wr) chk("op_wdata", m_wr_dat, o.data);
          chk("op_cycle", cyc, o.at);
        end
      end else begin
        chk("idle_m_addr", m_addr, 32'h0);
        chk("idle_m_wr_dat", m_wr_dat, 32'h0);
      end
      if (resp_valid) begin
        if (rsp_q.size() == 0) begin
          flag("unexpected_resp");
        end else begin
          r = rsp_q[0];
          if (!prev_v) chk("resp_cycle", cyc, r.at);
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
          chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
          if (resp_ready) void'(rsp_q.pop_front());
        end
      end
      prev_v = resp_valid;
    end
  endtask

  // Cycle offsets below are counted from the accept edge N as seen at the following negedge.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit do_rd, input bit do_wr,
                       input logic [31:0] wr_word, input bit do_resp,
                       input logic [31:0] exp_rd, input bit exp_err);
    bit   ok = 1'b0;
    int   n;
    int   at;
    op_t  o;
    rsp_t r;
    @(posedge clk); #1;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      flag("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    n  = cyc + 1;
    at = n;
    if (do_rd) begin
      o.wr = 1'b0; o.addr = {2'b00, addr[31:2]}; o.data = 32'h0; o.at = n;
      op_q.push_back(o);
      at = n + 2;
    end
    if (do_wr) begin
      o.wr = 1'b1; o.addr = {2'b00, addr[31:2]}; o.data = wr_word; o.at = at;
      op_q.push_back(o);
      at = at + 1;
    end
    if (do_resp) begin
      r.rdata = exp_rd; r.err = exp_err; r.at = at;
      rsp_q.push_back(r);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (op_q.size() == 0 && rsp_q.size() == 0 && req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      flag("drain_timeout");
      op_q.delete();
      rsp_q.delete();
    end
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, exp, 1'b0);
    drain();
  endtask

  task automatic do_rmw(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] merged);
    issue(1'b1, f3, addr, wd, 1'b1, 1'b1, merged, 1'b1, 32'h0, 1'b0);
    drain();
  endtask

  task automatic do_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    issue(we, f3, addr, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    drain();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_m_rd_en"}, {31'd0, m_rd_en}, 32'd0);
    chk({tag, "_m_wr_en"}, {31'd0, m_wr_en}, 32'd0);
    chk({tag, "_m_addr"}, m_addr, 32'h0);
    chk({tag, "_m_wr_dat"}, m_wr_dat, 32'h0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    @(negedge clk);
    tb_we = 1'b1; tb_waddr = 8'h40; tb_wdata = 32'h8899AABB;
    @(posedge clk); #1;
    tb_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

    do_load(F3_W,  32'h100, 32'h8899AABB);
    do_load(F3_B,  32'h103, 32'hFFFFFF88);
    do_load(F3_BU, 32'h103, 32'h00000088);
    do_load(F3_H,  32'h102, 32'hFFFF8899);
    do_load(F3_HU, 32'h100, 32'h0000AABB);

    do_rmw(F3_B, 32'h101, 32'h123456CC, 32'h8899CCBB);
    do_load(F3_W, 32'h100, 32'h8899CCBB);

    issue(1'b1, F3_W, 32'h104, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
    drain();
    do_load(F3_W, 32'h104, 32'hDEADBEEF);

    do_err(1'b0, F3_W,   32'h102);
    do_err(1'b1, F3_H,   32'h101);
    do_err(1'b0, 3'b011, 32'h100);
    do_err(1'b1, F3_BU,  32'h100);
    do_err(1'b0, F3_HU,  32'h103);

    do_rmw(F3_H, 32'h102, 32'h00007777, 32'h7777CCBB);
    do_load(F3_HU, 32'h102, 32'h00007777);

    // Response backpressure: five stalled cycles, then release.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue(1'b0, F3_W, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h7777CCBB, 1'b0);
    repeat (2) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_resp_held", {31'd0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    chk("release_resp_valid", {31'd0, resp_valid}, 32'd0);
    drain();

    // Reset during the WAIT cycle of an SH: the write must never happen.
    issue(1'b1, F3_H, 32'h100, 32'h00001234, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("wait_reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("wait_reset_m_wr_en", {31'd0, m_wr_en}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("mid_rmw");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rmw_dropped_mem", mem[8'h40], 32'h7777CCBB);
    chk("rmw_read_consumed", op_q.size(), 32'd0);

    do_load(F3_W, 32'h104, 32'hDEADBEEF);
    do_load(F3_W, 32'h100, 32'h7777CCBB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
